// File: rtl/hash_mask_pkg.sv
// hash_mask_pkg: shared lane geometry, XOR masks, FSM states and mask lookup for the hash unmask path
package hash_mask_pkg;
  localparam int LANES = 4;
  localparam int LANE_W = 32;
  localparam logic [LANE_W-1:0] MASK_EVEN = 32'h5A5A5A5A;
  localparam logic [LANE_W-1:0] MASK_ODD = 32'hA5A5A5A5;
  typedef enum logic [1:0] {IDLE, UNMASK, OUT} state_t;
  function automatic logic [LANE_W-1:0] mask_for_lane(
    input int unsigned idx,
    input logic [LANE_W-1:0] m_even = MASK_EVEN,
    input logic [LANE_W-1:0] m_odd = MASK_ODD
  );
    return (idx % 2) != 0 ? m_odd : m_even;
  endfunction
endpackage

// File: rtl/hash_unmask_rx_lane.sv
// hash_lane_unmask: combinational single-lane unmask
//   idx      lane index (selects even/odd mask)
//   lane_in  masked lane
//   lane_out lane_in XOR its mask
//   lane_par even parity of lane_in (only with HASH_RX_PARITY_CHK_EN)
module hash_lane_unmask #(
  parameter int LANE_W = hash_mask_pkg::LANE_W,
  parameter logic [LANE_W-1:0] MASK_EVEN = hash_mask_pkg::MASK_EVEN,
  parameter logic [LANE_W-1:0] MASK_ODD = hash_mask_pkg::MASK_ODD,
  parameter int IW = 2
) (
  input  logic [IW-1:0]     idx,
  input  logic [LANE_W-1:0] lane_in,
  output logic [LANE_W-1:0] lane_out
`ifdef HASH_RX_PARITY_CHK_EN
  , output logic            lane_par
`endif
);
  import hash_mask_pkg::*;
  assign lane_out = lane_in ^ mask_for_lane(32'(idx), MASK_EVEN, MASK_ODD);
`ifdef HASH_RX_PARITY_CHK_EN
  assign lane_par = ^lane_in;
`endif
endmodule

// File: rtl/hash_unmask_rx.sv
// hash_unmask_rx: removes the per-lane XOR mask from 128-bit blocks, one lane per cycle
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  masked block input handshake, in_data lane 0 in the MSBs
//   out_valid/out_ready unmasked block output handshake, out_data held until accepted
//   blk_cnt            wrapping count of output handshakes
//   busy               high whenever a block is in flight
//   Optional HASH_RX_PARITY_CHK_EN: in_par per-lane even parity, out_perr mismatch flag
module hash_unmask_rx #(
  parameter int LANES = hash_mask_pkg::LANES,
  parameter int LANE_W = hash_mask_pkg::LANE_W,
  parameter logic [LANE_W-1:0] MASK_EVEN = hash_mask_pkg::MASK_EVEN,
  parameter logic [LANE_W-1:0] MASK_ODD = hash_mask_pkg::MASK_ODD,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [CNT_W-1:0]        blk_cnt,
  output logic                    busy
`ifdef HASH_RX_PARITY_CHK_EN
  , input  logic [LANES-1:0]      in_par
  , output logic                  out_perr
`endif
);
  import hash_mask_pkg::*;
  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LANES*LANE_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LANE_W-1:0] lane, lane_x;
  // lane 0 sits in the MSBs, so lane i starts (LANES-1-i) lanes up from bit 0
  assign lane = blk_q[(LANES - 1 - int'(idx_q)) * LANE_W +: LANE_W];
`ifdef HASH_RX_PARITY_CHK_EN
  logic [LANES-1:0] par_q, par_d;
  logic perr_q, perr_d, lane_par;
`endif
  hash_lane_unmask #(
    .LANE_W(LANE_W), .MASK_EVEN(MASK_EVEN), .MASK_ODD(MASK_ODD), .IW(IW)
  ) u_lane (
    .idx(idx_q),
    .lane_in(lane),
    .lane_out(lane_x)
`ifdef HASH_RX_PARITY_CHK_EN
    , .lane_par(lane_par)
`endif
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    blk_d = blk_q;
    cnt_d = cnt_q;
`ifdef HASH_RX_PARITY_CHK_EN
    par_d = par_q;
    perr_d = perr_q;
`endif
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = UNMASK;
        idx_d = '0;
        blk_d = in_data;
`ifdef HASH_RX_PARITY_CHK_EN
        par_d = in_par;
        perr_d = 1'b0;
`endif
      end
      UNMASK: begin
        blk_d[(LANES - 1 - int'(idx_q)) * LANE_W +: LANE_W] = lane_x;
`ifdef HASH_RX_PARITY_CHK_EN
        perr_d = perr_q | (lane_par != par_q[idx_q]);
`endif
        idx_d = idx_q == LAST ? '0 : idx_q + IW'(1);
        state_d = idx_q == LAST ? OUT : UNMASK;
      end
      OUT: if (out_ready) begin
        state_d = IDLE;
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      blk_q <= '0;
      cnt_q <= '0;
`ifdef HASH_RX_PARITY_CHK_EN
      par_q <= '0;
      perr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      blk_q <= blk_d;
      cnt_q <= cnt_d;
`ifdef HASH_RX_PARITY_CHK_EN
      par_q <= par_d;
      perr_q <= perr_d;
`endif
    end
  assign in_ready = !rst && state_q == IDLE;
  assign out_valid = state_q == OUT;
  assign out_data = out_valid ? blk_q : '0;
  assign blk_cnt = cnt_q;
  assign busy = state_q != IDLE;
`ifdef HASH_RX_PARITY_CHK_EN
  assign out_perr = out_valid & perr_q;
`endif
endmodule

// File: tb/tb_hash_unmask_rx.sv
// tb_hash_unmask_rx: randomized and directed checks of hash_unmask_rx against a cycle-count reference model
module tb_hash_unmask_rx;
  import hash_mask_pkg::*;
  localparam int W = LANES * LANE_W;
  localparam logic [W-1:0] MASKS = {MASK_EVEN, MASK_ODD, MASK_EVEN, MASK_ODD};
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, busy, in_ready4, out_valid4, busy4;
  logic [W-1:0] out_data, out_data4;
  logic [15:0] blk_cnt;
  logic [3:0] blk_cnt4;
`ifdef HASH_RX_PARITY_CHK_EN
  logic [LANES-1:0] in_par = '0;
  logic out_perr, out_perr4;
`endif
  int total = 0, bad = 0;
  bit m_busy = 0, m_perr = 0;
  int m_left = 0, m_n = 0, m_in = 0;
  logic [W-1:0] m_exp = '0;
  logic ov;
  always #5 clk = ~clk;
  hash_unmask_rx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .blk_cnt(blk_cnt), .busy(busy)
`ifdef HASH_RX_PARITY_CHK_EN
    , .in_par(in_par), .out_perr(out_perr)
`endif
  );
  hash_unmask_rx #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .blk_cnt(blk_cnt4), .busy(busy4)
`ifdef HASH_RX_PARITY_CHK_EN
    , .in_par(in_par), .out_perr(out_perr4)
`endif
  );
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [LANES-1:0] par_of(input logic [W-1:0] d);
    logic [LANES-1:0] p;
    for (int i = 0; i < LANES; i++) p[i] = ^d[(LANES-1-i)*LANE_W +: LANE_W];
    return p;
  endfunction
  // Reference: a block is accepted when idle, spends LANES cycles unmasking, then waits for out_ready
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_busy = 0;
      m_left = 0;
      m_n = 0;
      m_perr = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1;
        m_left = LANES;
        m_exp = in_data ^ MASKS;
        m_in++;
`ifdef HASH_RX_PARITY_CHK_EN
        m_perr = in_par != par_of(in_data);
`endif
      end
    end else if (m_left > 0) m_left--;
    else if (out_ready) begin
      m_busy = 0;
      m_n++;
    end
  always @(negedge clk) begin
    ov = m_busy && m_left == 0;
    chk("in_ready", in_ready, !rst && !m_busy);
    chk("out_valid", out_valid, ov);
    chk("busy", busy, m_busy);
    chk("blk_cnt", blk_cnt, m_n % 65536);
    chk("blk_cnt4", blk_cnt4, m_n % 16);
    chk("in_ready4", in_ready4, !rst && !m_busy);
    chk("out_valid4", out_valid4, ov);
    chk("busy4", busy4, m_busy);
    if (ov) chk("out_data", out_data, m_exp);
    if (ov) chk("out_data4", out_data4, m_exp);
`ifdef HASH_RX_PARITY_CHK_EN
    chk("out_perr", out_perr, ov && m_perr);
    chk("out_perr4", out_perr4, ov && m_perr);
`endif
  end
  task automatic send(input logic [W-1:0] d, input logic [LANES-1:0] flip);
    int n0 = m_in;
    in_valid = 1;
    in_data = d;
`ifdef HASH_RX_PARITY_CHK_EN
    in_par = par_of(d) ^ flip;
`else
    if (flip != 0) in_data = d;
`endif
    for (int i = 0; i < 100 && m_in == n0; i++) @(negedge clk);
    chk("accept_timeout", 32'(m_in - n0), 1);
    #1 in_valid = 0;
  endtask
  task automatic wait_ov();
    for (int i = 0; i < 100 && !(m_busy && m_left == 0); i++) @(negedge clk);
    chk("ov_timeout", out_valid, 1);
  endtask
  task automatic wait_out();
    int n0 = m_n;
    for (int i = 0; i < 100 && m_n == n0; i++) @(negedge clk);
    chk("deliver_timeout", 32'(m_n - n0), 1);
    #1;
  endtask
  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    logic [W-1:0] d;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_busy", busy, 0);
    #1 rst = 0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    #1 out_ready = 1;
    send(MASKS, '0);
    for (int i = 1; i <= LANES; i++) begin
      @(negedge clk);
      chk("t1_latency", out_valid, i == LANES);
    end
    chk("t1_data", out_data, 0);
    @(negedge clk);
    chk("t1_blk_cnt", blk_cnt, 1);
    #1 send('0, 4'b0010);
    wait_ov();
    chk("t2_data", out_data, MASKS);
`ifdef HASH_RX_PARITY_CHK_EN
    chk("t2_perr", out_perr, 1);
`endif
    wait_out();
    out_ready = 0;
    d = rnd();
    send(d, '0);
    wait_ov();
    #1 in_valid = 1;
    in_data = rnd();
`ifdef HASH_RX_PARITY_CHK_EN
    in_par = par_of(in_data);
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_valid", out_valid, 1);
      chk("t3_data", out_data, d ^ MASKS);
      chk("t3_in_ready", in_ready, 0);
    end
    #1 out_ready = 1;
    @(negedge clk);
    chk("t3_ready_after_hs", in_ready, 1);
    chk("t3_valid_after_hs", out_valid, 0);
    @(negedge clk);
    chk("t3_second_accepted", busy, 1);
    #1 in_valid = 0;
    wait_out();
    send(rnd(), '0);
    repeat (2) @(negedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_busy", busy, 0);
    #1 rst = 0;
    repeat (8) begin
      @(negedge clk);
      chk("t5_no_output", out_valid, 0);
    end
    chk("t5_in_ready", in_ready, 1);
    chk("t5_blk_cnt", blk_cnt, 0);
    #1;
    for (int b = 0; b < 16; b++) begin
      send(rnd(), '0);
      wait_out();
    end
    chk("t6_wrap4", blk_cnt4, 0);
    chk("t6_cnt16", blk_cnt, 16);
    rst = 1;
    @(negedge clk);
    #1 rst = 0;
    for (int c = 0; c < 40000 && m_n < 1000; c++) begin
      in_valid = $urandom_range(0, 1) != 0;
      in_data = rnd();
`ifdef HASH_RX_PARITY_CHK_EN
      in_par = par_of(in_data) ^ ($urandom_range(0, 7) == 0 ? LANES'(1) << $urandom_range(0, LANES - 1) : '0);
`endif
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      #1;
    end
    in_valid = 0;
    chk("t4_blk_cnt", blk_cnt, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
